// File: rtl/ccheck_arb_pkg.sv
// Shared types for the checker register-read port arbiter and its clients.
package ccheck_arb_pkg;

    localparam int MAX_REQ    = 8;
    localparam int RSP_ID_W   = $clog2(MAX_REQ);
    localparam int RSP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Response layout at the default 32-bit data width and the widest requester id.
    typedef struct packed {
        logic [RSP_ID_W-1:0]   id;
        logic [RSP_DATA_W-1:0] rs_value;
        logic [RSP_DATA_W-1:0] rt_value;
        logic [RSP_DATA_W-1:0] rd_value;
        logic [RSP_DATA_W-1:0] pc;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    always_comb begin
        int              slot;
        logic [ID_W-1:0] sidx;
        logic            found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = 0;
        sidx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = int'(ptr) + k;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
            sidx = ID_W'(slot);
            if (!found && req[sidx]) begin
                found     = 1'b1;
                gnt[sidx] = 1'b1;
                gnt_idx   = sidx;
            end
        end
    end

endmodule

// File: rtl/ccheck_port_arbiter.sv
// Shares the checker's single register-read port among NUM_REQ requesters,
// one transaction at a time, returning a tagged one-cycle response.
module ccheck_port_arbiter
    import ccheck_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int READ_LAT = 1,
    parameter  int DATA_W   = 32,
    parameter  int IDX_W    = 5,
    localparam int ID_W     = $clog2(NUM_REQ),
    localparam int CNT_W    = $clog2(READ_LAT) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_rs,
    input  logic [NUM_REQ*IDX_W-1:0] req_rt,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_rs_value,
    output logic [DATA_W-1:0]        rsp_rt_value,
    output logic [DATA_W-1:0]        rsp_rd_value,
    output logic [DATA_W-1:0]        rsp_pc,
    output logic [IDX_W-1:0]         rs,
    output logic [IDX_W-1:0]         rt,
    input  logic [DATA_W-1:0]        rs_value,
    input  logic [DATA_W-1:0]        rt_value,
    input  logic [DATA_W-1:0]        rd_value,
    input  logic [DATA_W-1:0]        pc
);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] rs_value;
        logic [DATA_W-1:0] rt_value;
        logic [DATA_W-1:0] rd_value;
        logic [DATA_W-1:0] pc;
    } arb_rsp_t;

    state_t                          state_q, state_d;
    logic     [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic     [ID_W-1:0]             id_q, id_d;
    logic     [CNT_W-1:0]            cnt_q, cnt_d;
    logic     [IDX_W-1:0]            rs_q, rs_d;
    logic     [IDX_W-1:0]            rt_q, rt_d;
    arb_rsp_t                        rsp_q, rsp_d;
    logic                            rsp_valid_q, rsp_valid_d;

    logic     [NUM_REQ-1:0]            gnt;
    logic     [ID_W-1:0]               gnt_idx;
    logic                              hs;
    logic     [NUM_REQ-1:0][IDX_W-1:0] req_rs_a, req_rt_a;

    assign req_rs_a = req_rs;
    assign req_rt_a = req_rt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants only exist while idle and out of reset; gnt is already masked by req_valid.
    assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rsp_d       = rsp_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    rs_d     = req_rs_a[gnt_idx];
                    rt_d     = req_rt_a[gnt_idx];
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d    = CNT_W'(READ_LAT - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_d.id       = id_q;
                    rsp_d.rs_value = rs_value;
                    rsp_d.rt_value = rt_value;
                    rsp_d.rd_value = rd_value;
                    rsp_d.pc       = pc;
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rs           = rs_q;
    assign rt           = rt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_q.id;
    assign rsp_rs_value = rsp_q.rs_value;
    assign rsp_rt_value = rsp_q.rt_value;
    assign rsp_rd_value = rsp_q.rd_value;
    assign rsp_pc       = rsp_q.pc;

endmodule

// File: doc/ccheck_port_arbiter.md
Name: ccheck_port_arbiter

Overview:
- Round-robin arbiter sharing the checker's single register-read port (rs/rt index out; rs_value/rt_value/rd_value/pc back) among NUM_REQ checker-side requesters (scoreboard, trace monitor, debug dumper, ...).
- One outstanding transaction at a time. Holds rs/rt stable for READ_LAT cycles, samples the returned values, and delivers a one-cycle tagged response to the winning requester.
- Sits between the checker port's monitor-side modport and the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- READ_LAT, 1, cycles from rs/rt change to valid rs_value/rt_value (1..7)
- DATA_W, 32, width of value/pc buses
- IDX_W, 5, register index width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester read request
- req_rs  in  NUM_REQ*IDX_W  packed rs index per requester, slot i at [i*IDX_W +: IDX_W]
- req_rt  in  NUM_REQ*IDX_W  packed rt index per requester
- req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i]&&req_ready[i]
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  $clog2(NUM_REQ)  requester index owning the response
- rsp_rs_value  out  DATA_W  sampled rs_value
- rsp_rt_value  out  DATA_W  sampled rt_value
- rsp_rd_value  out  DATA_W  sampled rd_value
- rsp_pc  out  DATA_W  sampled pc
- rs  out  IDX_W  register index driven to the checker port
- rt  out  IDX_W  register index driven to the checker port
- rs_value, rt_value, rd_value, pc  in  DATA_W each  returned by the checker port

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; rr_ptr=0; rs=0; rt=0.
  - rsp_valid=0; rsp_id=0; all rsp_* data=0.
  - req_ready=0 while rst_n=0.
  - Reset mid-transaction aborts it: no rsp_valid is produced.
- FSM states:
  - IDLE:
    - req_ready is combinational, one-hot on the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready is 0 in all other states.
    - On handshake at edge T: rs<=req_rs[i]; rt<=req_rt[i]; id_q<=i; rr_ptr<=(i+1) mod NUM_REQ; cnt<=READ_LAT-1; go to WAIT.
  - WAIT:
    - If cnt==0: sample rs_value/rt_value/rd_value/pc into rsp_*, rsp_id<=id_q, rsp_valid<=1, go to RESP.
    - Otherwise cnt<=cnt-1.
  - RESP: rsp_valid=1 for exactly this cycle; next state IDLE; rsp_valid<=0.
- Latency: handshake in cycle T, rs/rt change in cycle T+1, sample at the end of cycle T+READ_LAT, rsp_valid high in cycle T+READ_LAT+1. Throughput is one transaction per READ_LAT+2 cycles.
- rs/rt hold their last value outside WAIT; they change only on a handshake.
- rsp_* data hold their last sampled value after rsp_valid drops.
- No response backpressure: requesters must accept rsp_valid when it is asserted.
- A requester may drop req_valid before the grant; there is no penalty and no grant is issued to it.
- With no req_valid asserted, rr_ptr is unchanged.
- rr_ptr wrap: after granting NUM_REQ-1, rr_ptr becomes 0.
- cnt width is $clog2(READ_LAT)+1 and holds values 0..READ_LAT-1.

Decomposition:
- Package ccheck_arb_pkg holds:
  - enum state_t {IDLE, WAIT, RESP}
  - a rsp_t struct {id, rs_value, rt_value, rd_value, pc}
  - constant MAX_REQ=8
- Sub-module rr_arbiter (NUM_REQ param): inputs req, ptr; output one-hot gnt plus binary gnt_idx. Purely combinational, reused elsewhere in the checker.
- FSM, counter and capture registers stay in ccheck_port_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rs=rt=0. After release, first grant goes to req 0.
- Single request, READ_LAT=1: req 2 asks rs=5, rt=9; model returns rs_value=32'hA5A5_0005, rt_value=32'h0000_0009, pc=32'h0040_0010 -> rs=5/rt=9 at T+1, rsp_valid at T+2 with rsp_id=2 and matching values.
- All four requesting continuously, READ_LAT=1 -> grant order 0,1,2,3,0,...; rsp_valid every 3 cycles; rs/rt stable through each WAIT.
- READ_LAT=3: model delays values 3 cycles after rs/rt change -> rsp_valid at T+4; values captured exactly at end of T+3, and garbage injected earlier is not captured.
- Requests 1 and 3 only with rr_ptr=2 -> 3 granted first, then 1; rr_ptr wraps 3->0.
- Reset asserted in WAIT -> no rsp_valid, state IDLE. A later request completes normally.
